// File: rtl/ir_sensor_intf_if.sv
// ir_sensor_intf_if -- signal bundle between the IR sensor sequencer and its
// neighbours (scan enable, A2D handshake, IR readings).
//   en         scan enable into the sequencer
//   IR_en      IR emitter enable
//   strt_cnv   one-cycle A2D conversion request
//   chnnl      A2D channel, held between requests
//   cnv_cmplt  one-cycle A2D done pulse, res valid in the same cycle
//   res        12-bit A2D result
//   IR_R0..3 / IR_L0..3  right/left readings, inside out
//   IR_vld     one-cycle pulse: all 8 readings updated
// master = sequencer side, slave = environment side (A2D + consumer).
interface ir_sensor_intf_if;
  logic        en;
  logic        IR_en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
  logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
  logic        IR_vld;

  modport master (
    input  en, cnv_cmplt, res,
    output IR_en, strt_cnv, chnnl, IR_vld,
    output IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3
  );

  modport slave (
    output en, cnv_cmplt, res,
    input  IR_en, strt_cnv, chnnl, IR_vld,
    input  IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3
  );
endinterface

// File: rtl/ir_sensor_intf.sv
// ir_sensor_intf -- periodic IR scan sequencer.
// Every PERIOD enabled clocks in IDLE it lights the IR emitters, waits SETTLE
// clocks, then walks the A2D through all 8 IR channels (R0,L0,R1,L1,R2,L2,R3,L3)
// and latches each result. IR_vld pulses one clock after the final capture.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ir_sensor_intf_if.master (en, A2D handshake, IR_en, readings, IR_vld)
// Parameters:
//   PERIOD  enabled IDLE clocks between scans
//   SETTLE  clocks IR_en is high before the first lit conversion request
// Optional build macro IR_SENSOR_AMBIENT_EN: an unlit ambient pass runs first
// and the lit readings are reported as saturating (lit - ambient).
module ir_sensor_intf #(
  parameter int PERIOD = 1048576,
  parameter int SETTLE = 4096
) (
  input  logic clk,
  input  logic rst_n,
  ir_sensor_intf_if.master bus
);
  localparam int CMAX = (PERIOD > SETTLE) ? PERIOD : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CONV, ST_WAIT, ST_GAP} state_t;

  state_t      state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [11:0] rd [8];
  logic        ir_en_q, strt_q, vld_q;
  logic [2:0]  chnnl_q;
  logic        idle_tc, settle_tc, cap, last;

`ifdef IR_SENSOR_AMBIENT_EN
  localparam logic AMB_EN = 1'b1;
  logic        amb;             // high while the unlit ambient pass runs
  logic [11:0] amb_rd [8];
`else
  localparam logic AMB_EN = 1'b0;
  localparam logic amb    = 1'b0;
`endif

  // scan index -> A2D channel
  function automatic logic [2:0] ch_map(input logic [2:0] i);
    case (i)
      3'd0: ch_map = 3'd1;
      3'd1: ch_map = 3'd0;
      3'd2: ch_map = 3'd4;
      3'd3: ch_map = 3'd2;
      3'd4: ch_map = 3'd3;
      3'd5: ch_map = 3'd7;
      3'd6: ch_map = 3'd6;
      default: ch_map = 3'd5;
    endcase
  endfunction

  assign idle_tc   = (state == ST_IDLE) && bus.en && (cnt == CW'(PERIOD - 1));
  assign settle_tc = (state == ST_SETTLE) && (cnt == CW'(SETTLE - 1));
  assign cap       = (state == ST_WAIT) && bus.cnv_cmplt;
  assign last      = cap && (idx == 3'd7);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (idle_tc) nxt = AMB_EN ? ST_CONV : ST_SETTLE;
      ST_SETTLE: if (settle_tc) nxt = ST_CONV;
      ST_CONV:   nxt = ST_WAIT;
      // GAP gives the one idle clock between a capture and the next request
      ST_WAIT:   if (cap) nxt = !last ? ST_GAP : (amb ? ST_SETTLE : ST_IDLE);
      ST_GAP:    nxt = ST_CONV;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      ir_en_q <= 1'b0;
      strt_q  <= 1'b0;
      chnnl_q <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rd[i] <= '0;
`ifdef IR_SENSOR_AMBIENT_EN
      amb <= 1'b0;
      for (int i = 0; i < 8; i++) amb_rd[i] <= '0;
`endif
    end else begin
      state <= nxt;
      // strt_cnv is high exactly while in CONV
      strt_q <= (nxt == ST_CONV);
      if (nxt == ST_CONV) chnnl_q <= ch_map(idx);
      vld_q <= last && !amb;

      if ((state == ST_IDLE && bus.en && !idle_tc) || (state == ST_SETTLE && !settle_tc))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      if ((idle_tc && !AMB_EN) || (last && amb)) ir_en_q <= 1'b1;
      else if (last)                             ir_en_q <= 1'b0;

      // idx wraps 7 -> 0 so each pass starts at index 0
      if (cap) begin
        idx <= idx + 1'b1;
`ifdef IR_SENSOR_AMBIENT_EN
        if (amb) amb_rd[idx] <= bus.res;
        else     rd[idx] <= (bus.res > amb_rd[idx]) ? bus.res - amb_rd[idx] : 12'h000;
`else
        rd[idx] <= bus.res;
`endif
      end

`ifdef IR_SENSOR_AMBIENT_EN
      if (idle_tc)   amb <= 1'b1;
      else if (last) amb <= 1'b0;
`endif
    end
  end

  assign bus.IR_en    = ir_en_q;
  assign bus.strt_cnv = strt_q;
  assign bus.chnnl    = chnnl_q;
  assign bus.IR_vld   = vld_q;
  assign bus.IR_R0    = rd[0];
  assign bus.IR_L0    = rd[1];
  assign bus.IR_R1    = rd[2];
  assign bus.IR_L1    = rd[3];
  assign bus.IR_R2    = rd[4];
  assign bus.IR_L2    = rd[5];
  assign bus.IR_R3    = rd[6];
  assign bus.IR_L3    = rd[7];
endmodule

// File: tb/tb_ir_sensor_intf.sv
// tb_ir_sensor_intf -- scoreboard bench for ir_sensor_intf (PERIOD=64, SETTLE=16).
// Stimulus pushes expected conversion requests and final reading sets into
// queues; a monitor pops and compares whenever strt_cnv or IR_vld is seen.
module tb_ir_sensor_intf;
  localparam int PERIOD = 64;
  localparam int SETTLE = 16;

  typedef logic [7:0][11:0] rd_t;   // [0]=R0,[1]=L0,[2]=R1,... scan order
  typedef struct packed {logic [2:0] ch; logic ir_en;} cnv_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_sensor_intf_if bus();
  ir_sensor_intf #(.PERIOD(PERIOD), .SETTLE(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, vld_cnt = 0, strt_cnt = 0, last_cmplt_cyc = -100, rst_epoch = 0;
  int t_ref = 0, arm_id = 0, rise_done = 0, strt_done = 0;
  bit amb_mode = 1'b0;
  logic [11:0] base = 12'h100;
  logic a2d_cmplt = 1'b0, stray = 1'b0;
  logic [11:0] a2d_res = '0;
  cnv_exp_t cnv_q[$];
  rd_t rd_q[$];
  int chmap[8] = '{1, 0, 4, 2, 3, 7, 6, 5};

  assign bus.cnv_cmplt = a2d_cmplt | stray;
  assign bus.res       = stray ? 12'hFFF : a2d_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rd_t dut_rd();
    return {bus.IR_L3, bus.IR_R3, bus.IR_L2, bus.IR_R2,
            bus.IR_L1, bus.IR_R1, bus.IR_L0, bus.IR_R0};
  endfunction

  task automatic check_reset(input string tag);
    rd_t r;
    r = dut_rd();
    chk({tag, "_IR_en"}, bus.IR_en, 0);
    chk({tag, "_strt"}, bus.strt_cnv, 0);
    chk({tag, "_chnnl"}, bus.chnnl, 0);
    chk({tag, "_vld"}, bus.IR_vld, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_rd%0d", tag, i), r[i], 0);
  endtask

  task automatic push_scan(input int n, input logic ir_en);
    cnv_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ch = 3'(chmap[i]);
      e.ir_en = ir_en;
      cnv_q.push_back(e);
    end
  endtask

  task automatic push_rd(input logic [11:0] b);
    rd_t r;
    for (int i = 0; i < 8; i++) r[i] = b + 12'(chmap[i]);
    rd_q.push_back(r);
  endtask

  task automatic wait_vld(input int n);
    int k = 0;
    while (vld_cnt < n && k < 2000) begin @(negedge clk); k++; end
    chk("vld_timeout", int'(vld_cnt >= n), 1);
  endtask

  task automatic wait_strt(input int n);
    int k = 0;
    while (strt_cnt < n && k < 2000) begin @(negedge clk); k++; end
    chk("strt_timeout", int'(strt_cnt >= n), 1);
  endtask

  task automatic pulse_stray();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
  endtask

  // A2D model: answers each request 10 clocks later unless reset intervened
  initial begin
    logic [2:0] ch;
    logic lit;
    int ep;
    forever begin
      @(negedge clk);
      if (bus.strt_cnv && rst_n) begin
        ch = bus.chnnl;
        lit = bus.IR_en;
        ep = rst_epoch;
        repeat (10) @(negedge clk);
        if (ep == rst_epoch) begin
          if (amb_mode) a2d_res = !lit ? 12'h050 : (ch == 3'd1 ? 12'h300 : 12'h030);
          else          a2d_res = base + 12'(ch);
          a2d_cmplt = 1'b1;
          last_cmplt_cyc = cyc;
          @(negedge clk);
          a2d_cmplt = 1'b0;
        end
      end
    end
  end

  // monitor
  logic prev_vld = 1'b0, prev_strt = 1'b0, prev_en = 1'b0;
  always @(negedge clk) begin
    cnv_exp_t e;
    rd_t a, x;
    if (bus.IR_en && !prev_en && rise_done != arm_id) begin
      chk("ir_en_rise_cyc", cyc - t_ref, PERIOD);
      rise_done = arm_id;
    end
    if (bus.strt_cnv) begin
      chk("strt_one_clk", prev_strt, 0);
      if (strt_done != arm_id) begin
        chk("first_strt_cyc", cyc - t_ref, PERIOD + SETTLE);
        strt_done = arm_id;
      end
      if (cnv_q.size() == 0) chk("unexpected_strt", 1, 0);
      else begin
        e = cnv_q.pop_front();
        chk("chnnl", bus.chnnl, e.ch);
        chk("ir_en_at_strt", bus.IR_en, e.ir_en);
      end
      strt_cnt++;
    end
    if (bus.IR_vld) begin
      chk("vld_one_clk", prev_vld, 0);
      chk("vld_after_cmplt", cyc - last_cmplt_cyc, 1);
      chk("ir_en_low_at_vld", bus.IR_en, 0);
      if (rd_q.size() == 0) chk("unexpected_vld", 1, 0);
      else begin
        x = rd_q.pop_front();
        a = dut_rd();
        for (int i = 0; i < 8; i++) chk($sformatf("rd%0d", i), a[i], x[i]);
      end
      vld_cnt++;
    end
    prev_vld = bus.IR_vld;
    prev_strt = bus.strt_cnv;
    prev_en = bus.IR_en;
  end

  initial begin
    rd_t r;
    int seen, s0;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
`ifdef IR_SENSOR_AMBIENT_EN
    amb_mode = 1'b1;
    push_scan(8, 1'b0);
    push_scan(8, 1'b1);
    r = '0;
    r[0] = 12'h2B0;
    rd_q.push_back(r);
    rst_n = 1'b1;
    wait_vld(1);
    repeat (100) @(negedge clk);
    chk("amb_single_vld", vld_cnt, 1);
`else
    // scan 1: timing from reset, hand-computed readings
    push_scan(8, 1'b1);
    rd_q.push_back({12'h105, 12'h106, 12'h107, 12'h103,
                    12'h102, 12'h104, 12'h100, 12'h101});
    t_ref = cyc;
    arm_id++;
    rst_n = 1'b1;
    wait_vld(1);

    // scan 2: stray completions in IDLE and SETTLE are ignored
    base = 12'h340;
    push_scan(8, 1'b1);
    push_rd(12'h340);
    repeat (5) @(negedge clk);
    pulse_stray();
    seen = 0;
    while (!bus.IR_en && seen < 200) begin @(negedge clk); seen++; end
    chk("settle_reached", bus.IR_en, 1);
    repeat (3) @(negedge clk);
    pulse_stray();
    r = dut_rd();
    for (int i = 0; i < 8; i++) chk($sformatf("stray_hold%0d", i), r[i], 12'h100 + chmap[i]);
    wait_vld(2);

    // en low: nothing happens
    bus.en = 1'b0;
    seen = 0;
    repeat (200) begin @(negedge clk); if (bus.IR_en) seen++; end
    chk("en0_no_ir_en", seen, 0);

    // scan 3: en dropped during third conversion, scan still completes
    bus.en = 1'b1;
    t_ref = cyc;
    arm_id++;
    base = 12'h200;
    push_scan(8, 1'b1);
    push_rd(12'h200);
    s0 = strt_cnt;
    wait_strt(s0 + 3);
    bus.en = 1'b0;
    wait_vld(3);
    repeat (200) @(negedge clk);
    chk("no_rescan_vld", vld_cnt, 3);
    chk("no_rescan_ir_en", bus.IR_en, 0);

    // scan 4: reset while waiting on index 4, then a full fresh scan
    bus.en = 1'b1;
    t_ref = cyc;
    arm_id++;
    base = 12'h0A0;
    push_scan(5, 1'b1);
    s0 = strt_cnt;
    wait_strt(s0 + 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    rst_epoch++;
    #1;
    check_reset("rst_mid");
    repeat (3) @(negedge clk);
    chk("no_vld_on_abort", vld_cnt, 3);
    base = 12'h0C0;
    push_scan(8, 1'b1);
    push_rd(12'h0C0);
    t_ref = cyc;
    arm_id++;
    rst_n = 1'b1;
    wait_vld(4);
`endif
    repeat (5) @(negedge clk);
    chk("cnv_q_empty", cnv_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_sensor_intf.md
Name: ir_sensor_intf

Overview:
Producer side of the IR-reading interface consumed by the error-compute path. It periodically turns on the IR emitters and waits a settling time. It then sequences the A2D interface through all 8 IR channels, latching each 12-bit result into IR_R0..IR_R3 / IR_L0..IR_L3. When the set is complete it pulses IR_vld for one clock.

Parameters:
PERIOD, 1048576, clocks from start of one scan period to start of the next settle (counted in IDLE)
SETTLE, 4096, clocks IR_en is held high before the first lit conversion

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable, sampled in IDLE only
IR_en  output  1  IR emitter enable
strt_cnv  output  1  one-cycle A2D conversion request
chnnl  output  3  A2D channel; valid with strt_cnv and held until cnv_cmplt
cnv_cmplt  input  1  one-cycle A2D done pulse; res valid in the same cycle
res  input  12  A2D result
IR_R0,IR_R1,IR_R2,IR_R3  output  12  right readings, inside out
IR_L0,IR_L1,IR_L2,IR_L3  output  12  left readings, inside out
IR_vld  output  1  one-cycle pulse: all 8 readings updated

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state IDLE, period counter 0, IR_en=0, strt_cnv=0, chnnl=0, IR_vld=0, all IR_* outputs 12'h000.
- All outputs are registered.
- Scan order, index 0..7:
  - Order: R0, L0, R1, L1, R2, L2, R3, L3.
  - A2D channel per index: 1, 0, 4, 2, 3, 7, 6, 5.
- IDLE:
  - While en=0, the counter is held at 0.
  - While en=1, the counter increments.
  - When the counter reaches PERIOD-1: counter clears, IR_en<=1, go to SETTLE.
- SETTLE: count SETTLE clocks with IR_en=1, then go to CONV with index 0.
- CONV: drive strt_cnv=1 for exactly one clock with chnnl = map(index), then go to WAIT.
- WAIT:
  - On cnv_cmplt, capture res into the output register for the current index.
  - If index<7: increment index and go to CONV. There is exactly one idle clock between cnv_cmplt and the next strt_cnv.
  - If index=7: IR_en<=0, IR_vld<=1 for exactly one clock (the clock after the L3 capture), go to IDLE.
- Each IR_* output changes only on its own capture.
  - Outputs are stable from IR_vld until the same channel is recaptured in the next period.
- cnv_cmplt outside WAIT is ignored.
- There is no timeout: WAIT holds indefinitely.
- en is ignored outside IDLE. Deasserting en mid-scan finishes the current scan, including IR_vld.
- Asynchronous reset mid-scan aborts immediately to reset values. IR_en drops with reset, and no IR_vld is produced.
- chnnl holds its last value between requests.

Optional Feature:
- Macro: IR_SENSOR_AMBIENT_EN.
- With the macro defined:
  - An ambient scan runs first. IDLE terminal count goes to an ambient CONV/WAIT pass over all 8 channels (same order) with IR_en=0.
  - Ambient results go to internal registers; the IR_* outputs are unchanged during this pass.
  - Then the block asserts IR_en, runs SETTLE, and runs the lit scan.
  - Captured value = lit - ambient if lit > ambient, else 12'h000 (saturating, no wrap).
  - IR_vld timing is relative to the lit L3 capture, as without the macro.
- Without the macro: no ambient pass, no ambient registers, raw res captured.

Test Plan:
1. Reset with PERIOD=64, SETTLE=16, en=1 → all outputs 0. IR_en rises at clock 64 after reset release. First strt_cnv with chnnl=1 comes 16 clocks later.
2. A2D model returns res = 12'h100 + chnnl, cnv_cmplt 10 clocks after strt_cnv → chnnl sequence 1,0,4,2,3,7,6,5.
   - Final values: IR_R0=0x101, IR_L0=0x100, IR_R1=0x104, IR_L1=0x102, IR_R2=0x103, IR_L2=0x107, IR_R3=0x106, IR_L3=0x105.
   - IR_vld is high for exactly one clock, the clock after the 8th cnv_cmplt, coincident with IR_en falling.
3. Stray cnv_cmplt pulses with res=0xFFF during IDLE and SETTLE → no output changes, no extra strt_cnv.
4. en=0 held for 200 clocks → no IR_en, no strt_cnv. Drop en during the 3rd conversion → scan completes and IR_vld pulses once, then no new scan.
5. Assert rst_n low while in WAIT for index 4 → immediate reset values, IR_vld stays 0. After release, the next scan starts after a full 64-clock IDLE.
6. With IR_SENSOR_AMBIENT_EN: ambient pass returns 0x050 on all channels with IR_en=0; lit pass returns 0x300 on ch1 and 0x030 elsewhere → IR_R0=0x2B0, all others 0x000, single IR_vld pulse after the lit L3 capture.
